// File: rtl/riscv_pkg.sv
// Shared definitions for the data-bus controller slice.
// Contents: RV32I load/store funct3 codes, the bus FSM state type and a
// word-address helper.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dbus_state_e;

    // The bus only ever sees word addresses; the low bits become byte enables.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational byte-lane alignment for the data bus.
// Request path: i_req_funct3/i_req_we/i_req_off/i_wdata -> o_be, o_wdata,
//               o_illegal (bad funct3), o_misalign (bad offset).
// Load path:    i_ld_funct3/i_ld_off/i_rdata -> o_rdata (extended result).
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_req_funct3,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_illegal,
    output logic        o_misalign,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // Request decode: legality, alignment, byte enables and replicated store data.
    always_comb begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_illegal  = 1'b0;
        o_misalign = 1'b0;
        if (i_req_we) begin
            case (i_req_funct3)
                F3_SB: begin
                    o_be    = 4'b0001 << i_req_off;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_SH: begin
                    o_be       = 4'b0011 << i_req_off;
                    o_wdata    = {2{i_wdata[15:0]}};
                    o_misalign = i_req_off[0];
                end
                F3_SW: begin
                    o_misalign = (i_req_off != 2'b00);
                end
                default: begin
                    o_illegal = 1'b1;
                end
            endcase
        end else begin
            case (i_req_funct3)
                F3_LB, F3_LBU: o_misalign = 1'b0;
                F3_LH, F3_LHU: o_misalign = i_req_off[0];
                F3_LW:         o_misalign = (i_req_off != 2'b00);
                default:       o_illegal  = 1'b1;
            endcase
        end
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        w_shifted = i_rdata >> {i_ld_off, 3'b000};
        case (i_ld_funct3)
            F3_LB:   o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_rdata = {24'd0, w_shifted[7:0]};
            F3_LHU:  o_rdata = {16'd0, w_shifted[15:0]};
            F3_LW:   o_rdata = i_rdata;
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/riscv_dbus_ctrl.sv
// Memory-stage data-bus controller.
// M-stage side: i_mem_reqM/i_mem_weM/i_funct3M/i_addrM/i_wdataM in;
//   o_bus_stallM (hazard unit), o_rdataM/o_rdata_vldM, o_excM, o_bus_errM out.
// Bus side: o_bus_req/we/addr/be/wdata out; i_bus_gnt/rvalid/rdata in.
// A legal access goes IDLE -> REQ -> (RESP for loads) -> DONE -> IDLE; a
// missing gnt/rvalid aborts to DONE with o_bus_errM after TIMEOUT_CYC cycles.
module riscv_dbus_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mem_reqM,
    input  logic        i_mem_weM,
    input  logic [2:0]  i_funct3M,
    input  logic [31:0] i_addrM,
    input  logic [31:0] i_wdataM,
    output logic        o_bus_stallM,
    output logic [31:0] o_rdataM,
    output logic        o_rdata_vldM,
    output logic        o_excM,
    output logic        o_bus_errM,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYC - 1);

    dbus_state_e r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [1:0]  r_off;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_bus_req;
    logic [31:0] r_rdata;
    logic        r_rdata_vld;
    logic        r_bus_err;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_illegal;
    logic        w_misalign;
    logic [31:0] w_ld_data;
    logic        w_exc;
    logic        w_stall;

    riscv_lsu_align u_align (
        .i_req_funct3 (i_funct3M),
        .i_req_we     (i_mem_weM),
        .i_req_off    (i_addrM[1:0]),
        .i_wdata      (i_wdataM),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_illegal    (w_illegal),
        .o_misalign   (w_misalign),
        .i_ld_funct3  (r_funct3),
        .i_ld_off     (r_off),
        .i_rdata      (i_bus_rdata),
        .o_rdata      (w_ld_data)
    );

    // Faulting accesses are flagged in IDLE and never reach the bus.
    assign w_exc = (r_state == IDLE) && i_mem_reqM && (w_illegal || w_misalign);

    // Stall covers the IDLE cycle of a legal access so the pipeline holds before REQ.
    always_comb begin
        case (r_state)
            IDLE:    w_stall = i_mem_reqM && !(w_illegal || w_misalign);
            REQ:     w_stall = 1'b1;
            RESP:    w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    // Bus FSM with request capture, timeout counter and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_addr      <= 32'd0;
            r_off       <= 2'd0;
            r_we        <= 1'b0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_funct3    <= 3'd0;
            r_bus_req   <= 1'b0;
            r_rdata     <= 32'd0;
            r_rdata_vld <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt       <= 8'd0;
                    r_rdata_vld <= 1'b0;
                    r_bus_err   <= 1'b0;
                    if (i_mem_reqM && !(w_illegal || w_misalign)) begin
                        r_addr    <= word_addr(i_addrM);
                        r_off     <= i_addrM[1:0];
                        r_we      <= i_mem_weM;
                        r_be      <= w_be;
                        r_wdata   <= w_wdata;
                        r_funct3  <= i_funct3M;
                        r_bus_req <= 1'b1;
                        r_state   <= REQ;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (i_bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_state   <= r_we ? DONE : RESP;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_state   <= REQ;
                    end
                end
                RESP: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (i_bus_rvalid) begin
                        r_rdata     <= w_ld_data;
                        r_rdata_vld <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_bus_err <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_state   <= RESP;
                    end
                end
                DONE: begin
                    r_cnt       <= 8'd0;
                    r_rdata_vld <= 1'b0;
                    r_bus_err   <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_bus_stallM = w_stall;
    assign o_excM       = w_exc;
    assign o_rdataM     = r_rdata;
    assign o_rdata_vldM = r_rdata_vld;
    assign o_bus_errM   = r_bus_err;
    assign o_bus_req    = r_bus_req;
    assign o_bus_we     = r_we;
    assign o_bus_addr   = r_addr;
    assign o_bus_be     = r_be;
    assign o_bus_wdata  = r_wdata;

endmodule
